vtx_mem_txn_capture: RTL and testbench

VTX_MEM_TXN_CAPTURE -- requirements
Module: vtx_mem_txn_capture

---
 rtl/vtx_mem_txn_capture.sv | 244 ++++++++++++++++++++++++
 tb/tb_vtx_mem_txn_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vtx_mem_txn_capture.sv
// -----------------------------------------------------------------------------
// vtx_mem_txn_capture
//
// Captures up to NUM_TXN memory transactions (request fields plus in-order
// response data) issued while one instruction executes. On instr_retire the
// collected working state is copied into a registered snapshot and vtx_valid
// pulses for one cycle on the following cycle.
//
// Parameters
//   NUM_TXN : transaction slots per instruction (1..16)
//   AW      : memory address width
//   DW      : memory data width (multiple of 8), BW = DW/8 byte enables
//
// Ports
//   vtx_clk, vtx_resetn           : clock, asynchronous active-low reset
//   mem_req/mem_gnt               : request handshake, accepted when both are 1
//   mem_wen/addr/wdata/ben        : request fields, sampled on acceptance
//   mem_rsp_valid/rdata/error     : in-order response for the oldest request
//   instr_retire                  : current instruction completes this cycle
//   vtx_valid                     : one-cycle pulse, snapshot outputs are new
//   vtx_mem_cen/wen/error         : per-slot flags, slot i at bit i
//   vtx_mem_addr/wdata/rdata/ben  : packed slot fields, slot i at i*width
//   vtx_mem_count                 : min(accepted requests, NUM_TXN)
//   vtx_mem_overflow/proto_err    : sticky per-instruction error flags
// -----------------------------------------------------------------------------
module vtx_mem_txn_capture #(
    parameter int NUM_TXN = 4,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic                    vtx_clk,
    input  logic                    vtx_resetn,
    input  logic                    mem_req,
    input  logic                    mem_gnt,
    input  logic                    mem_wen,
    input  logic [AW-1:0]           mem_addr,
    input  logic [DW-1:0]           mem_wdata,
    input  logic [DW/8-1:0]         mem_ben,
    input  logic                    mem_rsp_valid,
    input  logic [DW-1:0]           mem_rdata,
    input  logic                    mem_error,
    input  logic                    instr_retire,
    output logic                    vtx_valid,
    output logic [NUM_TXN-1:0]      vtx_mem_cen,
    output logic [NUM_TXN-1:0]      vtx_mem_wen,
    output logic [NUM_TXN-1:0]      vtx_mem_error,
    output logic [NUM_TXN*AW-1:0]   vtx_mem_addr,
    output logic [NUM_TXN*DW-1:0]   vtx_mem_wdata,
    output logic [NUM_TXN*DW-1:0]   vtx_mem_rdata,
    output logic [NUM_TXN*DW/8-1:0] vtx_mem_ben,
    output logic [4:0]              vtx_mem_count,
    output logic                    vtx_mem_overflow,
    output logic                    vtx_mem_proto_err
);

    localparam int BW = DW / 8;
    localparam int PW = $clog2(NUM_TXN + 1);   // pointers span 0..NUM_TXN
    localparam int OW = 8;                     // outstanding counter width

    // ---------------- working state ----------------
    logic [NUM_TXN-1:0]    cen_q,   cen_d;
    logic [NUM_TXN-1:0]    wen_q,   wen_d;
    logic [NUM_TXN-1:0]    err_q,   err_d;
    logic [NUM_TXN*AW-1:0] addr_q,  addr_d;
    logic [NUM_TXN*DW-1:0] wdata_q, wdata_d;
    logic [NUM_TXN*DW-1:0] rdata_q, rdata_d;
    logic [NUM_TXN*BW-1:0] ben_q,   ben_d;
    logic [PW-1:0]         req_ptr_q, req_ptr_d;
    logic [PW-1:0]         rsp_ptr_q, rsp_ptr_d;
    logic [OW-1:0]         out_q,   out_d;     // all outstanding requests
    logic [OW-1:0]         stale_q, stale_d;   // outstanding ones issued by retired instructions
    logic                  ovf_q,   ovf_d;
    logic                  perr_q,  perr_d;

    // Working state after this cycle's response, before retire/acceptance.
    logic [NUM_TXN-1:0]    err_r;
    logic [NUM_TXN*DW-1:0] rdata_r;
    logic [PW-1:0]         rsp_ptr_r;
    logic [OW-1:0]         out_r;
    logic [OW-1:0]         stale_r;
    logic                  perr_r;
    logic                  acc;
    logic                  rsp_fill;

    // ---------------- snapshot ----------------
    logic                  valid_q;
    logic [NUM_TXN-1:0]    snap_cen_q, snap_wen_q, snap_err_q;
    logic [NUM_TXN*AW-1:0] snap_addr_q;
    logic [NUM_TXN*DW-1:0] snap_wdata_q, snap_rdata_q;
    logic [NUM_TXN*BW-1:0] snap_ben_q;
    logic [4:0]            snap_count_q;
    logic                  snap_ovf_q, snap_perr_q;

    always_comb begin
        // NOTE: every variable written here is given a value before any
        // conditional update, so no path can leave it holding (no latch).
        acc = mem_req & mem_gnt;

        // A response belongs to the current instruction only when nothing
        // older is still in flight; otherwise it is late (or unsolicited).
        rsp_fill  = mem_rsp_valid & (out_q != '0) & (stale_q == '0);
        err_r     = err_q;
        rdata_r   = rdata_q;
        rsp_ptr_r = rsp_ptr_q;
        perr_r    = perr_q | (mem_rsp_valid & ~rsp_fill);
        if (rsp_fill && (int'(rsp_ptr_q) < NUM_TXN)) begin
            err_r[int'(rsp_ptr_q) +: 1]     = mem_error;
            rdata_r[int'(rsp_ptr_q)*DW +: DW] = mem_rdata;
            rsp_ptr_r                         = rsp_ptr_q + PW'(1);
        end
        out_r   = out_q   - OW'(mem_rsp_valid & (out_q != '0));
        stale_r = stale_q - OW'(mem_rsp_valid & (stale_q != '0));

        // Retire clears the slots; whatever is still outstanding now belongs
        // to a finished instruction and is tracked as stale.
        if (instr_retire) begin
            cen_d     = '0;
            wen_d     = '0;
            err_d     = '0;
            addr_d    = '0;
            wdata_d   = '0;
            rdata_d   = '0;
            ben_d     = '0;
            req_ptr_d = '0;
            rsp_ptr_d = '0;
            ovf_d     = 1'b0;
            perr_d    = 1'b0;
            stale_d   = out_r;
        end else begin
            cen_d     = cen_q;
            wen_d     = wen_q;
            err_d     = err_r;
            addr_d    = addr_q;
            wdata_d   = wdata_q;
            rdata_d   = rdata_r;
            ben_d     = ben_q;
            req_ptr_d = req_ptr_q;
            rsp_ptr_d = rsp_ptr_r;
            ovf_d     = ovf_q;
            perr_d    = perr_r;
            stale_d   = stale_r;
        end
        out_d = out_r;

        // Acceptance is applied last so a request coinciding with retire
        // lands in slot 0 of the freshly cleared state.
        if (acc) begin
            if (int'(req_ptr_d) < NUM_TXN) begin
                cen_d[int'(req_ptr_d) +: 1]       = 1'b1;
                wen_d[int'(req_ptr_d) +: 1]       = mem_wen;
                addr_d[int'(req_ptr_d)*AW +: AW]  = mem_addr;
                wdata_d[int'(req_ptr_d)*DW +: DW] = mem_wdata;
                ben_d[int'(req_ptr_d)*BW +: BW]   = mem_ben;
                req_ptr_d                         = req_ptr_d + PW'(1);
            end else begin
                ovf_d = 1'b1;
            end
            if (out_d != '1) begin
                out_d = out_d + OW'(1);
            end
        end
    end

    // NOTE: the slot arrays are reset like any other register because unused
    // snapshot slots must read as zero straight out of reset.
    always_ff @(posedge vtx_clk or negedge vtx_resetn) begin
        if (!vtx_resetn) begin
            cen_q     <= '0;
            wen_q     <= '0;
            err_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ben_q     <= '0;
            req_ptr_q <= '0;
            rsp_ptr_q <= '0;
            out_q     <= '0;
            stale_q   <= '0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            cen_q     <= cen_d;
            wen_q     <= wen_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ben_q     <= ben_d;
            req_ptr_q <= req_ptr_d;
            rsp_ptr_q <= rsp_ptr_d;
            out_q     <= out_d;
            stale_q   <= stale_d;
            ovf_q     <= ovf_d;
            perr_q    <= perr_d;
        end
    end

    // Snapshot: includes this cycle's response but not this cycle's request.
    always_ff @(posedge vtx_clk or negedge vtx_resetn) begin
        if (!vtx_resetn) begin
            valid_q      <= 1'b0;
            snap_cen_q   <= '0;
            snap_wen_q   <= '0;
            snap_err_q   <= '0;
            snap_addr_q  <= '0;
            snap_wdata_q <= '0;
            snap_rdata_q <= '0;
            snap_ben_q   <= '0;
            snap_count_q <= '0;
            snap_ovf_q   <= 1'b0;
            snap_perr_q  <= 1'b0;
        end else begin
            valid_q <= instr_retire;
            if (instr_retire) begin
                snap_cen_q   <= cen_q;
                snap_wen_q   <= wen_q;
                snap_err_q   <= err_r;
                snap_addr_q  <= addr_q;
                snap_wdata_q <= wdata_q;
                snap_rdata_q <= rdata_r;
                snap_ben_q   <= ben_q;
                snap_count_q <= 5'(req_ptr_q);
                snap_ovf_q   <= ovf_q;
                // Retiring with requests still in flight is a protocol error.
                snap_perr_q  <= perr_r | (out_r != '0);
            end
        end
    end

    assign vtx_valid         = valid_q;
    assign vtx_mem_cen       = snap_cen_q;
    assign vtx_mem_wen       = snap_wen_q;
    assign vtx_mem_error     = snap_err_q;
    assign vtx_mem_addr      = snap_addr_q;
    assign vtx_mem_wdata     = snap_wdata_q;
    assign vtx_mem_rdata     = snap_rdata_q;
    assign vtx_mem_ben       = snap_ben_q;
    assign vtx_mem_count     = snap_count_q;
    assign vtx_mem_overflow  = snap_ovf_q;
    assign vtx_mem_proto_err = snap_perr_q;

endmodule

// File: tb/tb_vtx_mem_txn_capture.sv
// -----------------------------------------------------------------------------
// tb_vtx_mem_txn_capture
//
// Directed-vector bench. Two instances share one stimulus stream:
//   dut_a : NUM_TXN=4, AW=32, DW=32 (low halves of the data buses)
//   dut_b : NUM_TXN=1, AW=32, DW=64
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_vtx_mem_txn_capture;

    logic        vtx_clk = 1'b0;
    logic        vtx_resetn;
    logic        mem_req, mem_gnt, mem_wen, mem_rsp_valid, mem_error, instr_retire;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_ben;

    logic         a_valid, a_ovf, a_perr;
    logic [3:0]   a_cen, a_wen, a_err;
    logic [127:0] a_addr, a_wdata, a_rdata;
    logic [15:0]  a_ben;
    logic [4:0]   a_count;

    logic         b_valid, b_ovf, b_perr;
    logic [0:0]   b_cen, b_wen, b_err;
    logic [31:0]  b_addr;
    logic [63:0]  b_wdata, b_rdata;
    logic [7:0]   b_ben;
    logic [4:0]   b_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 vtx_clk = ~vtx_clk;

    vtx_mem_txn_capture #(.NUM_TXN(4), .AW(32), .DW(32)) dut_a (
        .vtx_clk(vtx_clk), .vtx_resetn(vtx_resetn),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata[31:0]), .mem_ben(mem_ben[3:0]),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata[31:0]), .mem_error(mem_error),
        .instr_retire(instr_retire), .vtx_valid(a_valid),
        .vtx_mem_cen(a_cen), .vtx_mem_wen(a_wen), .vtx_mem_error(a_err),
        .vtx_mem_addr(a_addr), .vtx_mem_wdata(a_wdata), .vtx_mem_rdata(a_rdata),
        .vtx_mem_ben(a_ben), .vtx_mem_count(a_count),
        .vtx_mem_overflow(a_ovf), .vtx_mem_proto_err(a_perr)
    );

    vtx_mem_txn_capture #(.NUM_TXN(1), .AW(32), .DW(64)) dut_b (
        .vtx_clk(vtx_clk), .vtx_resetn(vtx_resetn),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ben(mem_ben),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .instr_retire(instr_retire), .vtx_valid(b_valid),
        .vtx_mem_cen(b_cen), .vtx_mem_wen(b_wen), .vtx_mem_error(b_err),
        .vtx_mem_addr(b_addr), .vtx_mem_wdata(b_wdata), .vtx_mem_rdata(b_rdata),
        .vtx_mem_ben(b_ben), .vtx_mem_count(b_count),
        .vtx_mem_overflow(b_ovf), .vtx_mem_proto_err(b_perr)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given inputs; handshake strobes drop afterwards.
    task automatic step(input logic req, input logic gnt, input logic wen,
                        input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [7:0] ben, input logic rsp,
                        input logic [63:0] rdata, input logic err, input logic ret);
        mem_req       = req;
        mem_gnt       = gnt;
        mem_wen       = wen;
        mem_addr      = addr;
        mem_wdata     = wdata;
        mem_ben       = ben;
        mem_rsp_valid = rsp;
        mem_rdata     = rdata;
        mem_error     = err;
        instr_retire  = ret;
        @(posedge vtx_clk);
        #1;
        mem_req       = 1'b0;
        mem_gnt       = 1'b0;
        mem_wen       = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_error     = 1'b0;
        instr_retire  = 1'b0;
    endtask

    task automatic t_req(input logic [31:0] addr);
        step(1'b1, 1'b1, 1'b0, addr, 64'h0, 8'hFF, 1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic t_rsp(input logic [63:0] rdata, input logic err);
        step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00, 1'b1, rdata, err, 1'b0);
    endtask

    task automatic t_ret();
        step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 1'b1);
    endtask

    task automatic t_idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [63:0] rd(input int i);
        return {32'hFACE_0000 + 32'(i), 32'h0000_00A0 + 32'(i)};
    endfunction

    initial begin
        vtx_resetn    = 1'b0;
        mem_req       = 1'b0;
        mem_gnt       = 1'b0;
        mem_wen       = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_ben       = '0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        mem_error     = 1'b0;
        instr_retire  = 1'b0;
        repeat (2) @(posedge vtx_clk);
        #1;

        // ---- reset state ----
        check("rst_valid", a_valid, 0);
        check("rst_count", a_count, 0);
        check("rst_cen",   a_cen,   0);
        check("rst_addr",  a_addr,  0);
        check("rst_flags", {a_ovf, a_perr}, 0);
        check("rst_b_valid", b_valid, 0);
        vtx_resetn = 1'b1;

        // ---- single load, response, retire; a req without gnt is ignored ----
        step(1'b1, 1'b0, 1'b0, 32'h999, 64'h0, 8'hFF, 1'b0, 64'h0, 1'b0, 1'b0);
        t_req(32'h100);
        t_idle();
        t_rsp(64'hDEADBEEF, 1'b0);
        t_ret();
        check("s1_valid", a_valid, 1);
        check("s1_count", a_count, 1);
        check("s1_cen",   a_cen,   4'b0001);
        check("s1_addr",  a_addr,  128'h100);
        check("s1_rdata", a_rdata, 128'hDEADBEEF);
        check("s1_flags", {a_ovf, a_perr}, 2'b00);
        t_idle();
        check("s1_pulse", a_valid, 0);
        check("s1_hold",  a_count, 1);

        // ---- six requests, responses overlapping the next request ----
        t_req(32'h10);
        for (int i = 2; i <= 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'(i * 16), 64'h0, 8'hFF,
                 1'b1, rd(i - 1), (i - 1) == 2, 1'b0);
        end
        t_rsp(rd(6), 1'b0);
        t_ret();
        check("s2_valid", a_valid, 1);
        check("s2_count", a_count, 4);
        check("s2_cen",   a_cen,   4'b1111);
        check("s2_flags", {a_ovf, a_perr}, 2'b10);
        check("s2_addr",  a_addr,  128'h00000040_00000030_00000020_00000010);
        check("s2_rdata", a_rdata, 128'h000000A4_000000A3_000000A2_000000A1);
        check("s2_err",   a_err,   4'b0010);
        check("s2_b_count", b_count, 1);
        check("s2_b_flags", {b_ovf, b_perr}, 2'b10);
        check("s2_b_addr",  b_addr,  32'h10);
        check("s2_b_rdata", b_rdata, 64'hFACE0001_000000A1);

        // ---- store accepted in the retire cycle goes to the next snapshot ----
        step(1'b1, 1'b1, 1'b1, 32'h300, 64'h12345678, 8'h03, 1'b0, 64'h0, 1'b0, 1'b1);
        check("s3_valid", a_valid, 1);
        check("s3_count", a_count, 0);
        check("s3_cen",   a_cen,   0);
        check("s3_flags", {a_ovf, a_perr}, 2'b00);
        t_rsp(64'h0, 1'b0);
        t_ret();
        check("s3n_count", a_count, 1);
        check("s3n_cen",   a_cen,   4'b0001);
        check("s3n_wen",   a_wen,   4'b0001);
        check("s3n_ben",   a_ben,   16'h0003);
        check("s3n_wdata", a_wdata, 128'h12345678);
        check("s3n_addr",  a_addr,  128'h300);
        check("s3n_perr",  a_perr,  0);
        t_ret();
        check("b2b_valid", a_valid, 1);
        check("b2b_count", a_count, 0);
        check("b2b_cen",   a_cen,   0);
        check("b2b_addr",  a_addr,  0);

        // ---- retire before response; late and unsolicited responses ----
        t_req(32'h400);
        t_ret();
        check("s4_perr",  a_perr,  1);
        check("s4_count", a_count, 1);
        t_rsp(64'h55, 1'b0);
        t_ret();
        check("s4l_perr",  a_perr,  1);
        check("s4l_count", a_count, 0);
        check("s4l_rdata", a_rdata, 0);
        t_rsp(64'h66, 1'b0);
        t_ret();
        check("s4u_perr",  a_perr,  1);

        // ---- reset mid-instruction ----
        t_req(32'hA);
        t_req(32'hB);
        vtx_resetn = 1'b0;
        #2;
        check("s5_rst_valid", a_valid, 0);
        check("s5_rst_perr",  a_perr,  0);
        check("s5_rst_b_perr", b_perr, 0);
        @(posedge vtx_clk);
        #1;
        vtx_resetn = 1'b1;
        t_req(32'hC);
        check("s5_novalid", a_valid, 0);
        t_rsp(64'h01234567_89ABCDEF, 1'b0);
        t_ret();
        check("s5_valid", a_valid, 1);
        check("s5_count", a_count, 1);
        check("s5_addr",  a_addr,  128'hC);
        check("s5_rdata", a_rdata, 128'h89ABCDEF);
        check("s5_flags", {a_ovf, a_perr}, 2'b00);
        check("s5_b_valid", b_valid, 1);
        check("s5_b_count", b_count, 1);
        check("s5_b_addr",  b_addr,  32'hC);
        check("s5_b_rdata", b_rdata, 64'h01234567_89ABCDEF);
        check("s5_b_flags", {b_ovf, b_perr}, 2'b00);
        t_idle();
        check("s5_single", a_valid, 0);

        // ---- single-slot overflow ----
        t_req(32'h1000);
        t_req(32'h2000);
        t_rsp(64'hCAFE0000_00000001, 1'b1);
        t_rsp(64'hCAFE0000_00000002, 1'b0);
        t_ret();
        check("s6_b_count", b_count, 1);
        check("s6_b_flags", {b_ovf, b_perr}, 2'b10);
        check("s6_b_addr",  b_addr,  32'h1000);
        check("s6_b_rdata", b_rdata, 64'hCAFE0000_00000001);
        check("s6_b_err",   b_err,   1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
